// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the frame-level UART transmit arbiter:
// FSM encodings, header default, bit timing used alongside uart_tx.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HDR  = 2'd1,
        ST_FETCH     = 2'd2,
        ST_WAIT_DATA = 2'd3
    } arb_state_t;

    localparam logic [7:0] HDR_BASE_DEF = 8'hA0;
    localparam int         CLKS_PER_BIT = 4;

    // Header carries the source id in its low three bits.
    function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [2:0] id);
        return base | {5'b0, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request found searching from
// last_id+1 upward, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_id,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               any
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(last_id) + i) % NUM_REQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte-stream sources, one whole frame per
// grant, with an optional source-id header byte in front of each frame.
//
// state      | meaning
// IDLE       | no owner; arbitrate when uart_tx is free and someone is valid
// WAIT_HDR   | header byte handed to uart_tx, waiting for its done
// FETCH      | ready offered to the owner; timeout counts here only
// WAIT_DATA  | data byte handed to uart_tx, waiting for its done
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter int         HDR_EN   = 1,
    parameter logic [7:0] HDR_BASE = HDR_BASE_DEF,
    parameter int         TIMEOUT  = 65535
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [NUM_REQ*8-1:0]   i_req_byte,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_tx_dv,
    output logic [7:0]             o_tx_byte,
    input  logic                   i_tx_active,
    input  logic                   i_tx_done,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_busy,
    output logic                   o_abort
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t         state, state_nxt;
    logic [IDW-1:0]     last_id, last_id_nxt;
    logic [IDW-1:0]     grant_id, grant_id_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic               tx_dv_nxt;
    logic [7:0]         tx_byte_nxt;
    logic               abort_nxt;
    logic               last_q, last_q_nxt;
    logic [TW-1:0]      tmr, tmr_nxt;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDW-1:0]     arb_id;
    logic               arb_any;
    logic [7:0]         sel_byte;
    logic               sel_last;
    logic               handshake;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req     (i_req_valid),
        .last_id (last_id),
        .gnt     (arb_gnt),
        .gnt_id  (arb_id),
        .any     (arb_any)
    );

    always_comb begin
        sel_byte = 8'h00;
        sel_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == IDW'(k)) begin
                sel_byte = i_req_byte[8*k +: 8];
                sel_last = i_req_last[k];
            end
        end
    end

    assign handshake = (state == ST_FETCH) && (|(o_grant & i_req_valid));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state     <= ST_IDLE;
            last_id   <= IDW'(NUM_REQ - 1);
            grant_id  <= '0;
            o_grant   <= '0;
            o_tx_dv   <= 1'b0;
            o_tx_byte <= 8'h00;
            o_abort   <= 1'b0;
            last_q    <= 1'b0;
            tmr       <= '0;
        end else begin
            state     <= state_nxt;
            last_id   <= last_id_nxt;
            grant_id  <= grant_id_nxt;
            o_grant   <= grant_nxt;
            o_tx_dv   <= tx_dv_nxt;
            o_tx_byte <= tx_byte_nxt;
            o_abort   <= abort_nxt;
            last_q    <= last_q_nxt;
            tmr       <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_id_nxt  = last_id;
        grant_id_nxt = grant_id;
        grant_nxt    = o_grant;
        tx_dv_nxt    = 1'b0;
        tx_byte_nxt  = o_tx_byte;
        abort_nxt    = 1'b0;
        last_q_nxt   = last_q;
        tmr_nxt      = tmr;
        case (state)
            ST_IDLE: begin
                if (!i_tx_active && arb_any) begin
                    grant_nxt    = arb_gnt;
                    grant_id_nxt = arb_id;
                    if (HDR_EN != 0) begin
                        tx_dv_nxt   = 1'b1;
                        tx_byte_nxt = hdr_byte(HDR_BASE, 3'(arb_id));
                        state_nxt   = ST_WAIT_HDR;
                    end else begin
                        tmr_nxt   = TW'(TIMEOUT);
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_WAIT_HDR: begin
                if (i_tx_done) begin
                    tmr_nxt   = TW'(TIMEOUT);
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Down-counter reloaded on every entry; terminal count of 1
                // means TIMEOUT idle FETCH cycles have elapsed.
                if (handshake) begin
                    tx_dv_nxt   = 1'b1;
                    tx_byte_nxt = sel_byte;
                    last_q_nxt  = sel_last;
                    state_nxt   = ST_WAIT_DATA;
                end else if (TIMEOUT != 0 && tmr == TW'(1)) begin
                    abort_nxt   = 1'b1;
                    last_id_nxt = grant_id;
                    grant_nxt   = '0;
                    state_nxt   = ST_IDLE;
                end else if (TIMEOUT != 0) begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            ST_WAIT_DATA: begin
                if (i_tx_done) begin
                    if (last_q) begin
                        last_id_nxt = grant_id;
                        grant_nxt   = '0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        tmr_nxt   = TW'(TIMEOUT);
                        state_nxt = ST_FETCH;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        if (state == ST_FETCH) begin
            o_req_ready = o_grant & i_req_valid;
        end
        o_busy = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued source frames, a behavioural
// uart_tx stand-in, and expected bytes/grants compared on each start pulse.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int N        = 4;
    localparam int TO       = 20;
    localparam int UART_CYC = CLKS_PER_BIT * 10;

    typedef struct packed {
        logic [7:0]   b;
        logic [N-1:0] g;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]   valid1 = '0, last1 = '0, ready1, grant1;
    logic [N*8-1:0] byte1  = '0;
    logic           tx_dv1, busy1, abort1;
    logic [7:0]     tx_byte1;
    logic           active1 = 1'b0, done1 = 1'b0;

    logic [N-1:0]   valid2 = '0, last2 = '0, ready2, grant2;
    logic [N*8-1:0] byte2  = '0;
    logic           tx_dv2, busy2, abort2;
    logic [7:0]     tx_byte2;
    logic           active2 = 1'b0, done2 = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(N), .HDR_EN(1), .HDR_BASE(8'hA0), .TIMEOUT(TO)) u_dut (
        .i_Clk(clk), .i_Rst(rst), .i_req_valid(valid1), .i_req_byte(byte1),
        .i_req_last(last1), .o_req_ready(ready1), .o_tx_dv(tx_dv1), .o_tx_byte(tx_byte1),
        .i_tx_active(active1), .i_tx_done(done1), .o_grant(grant1), .o_busy(busy1),
        .o_abort(abort1));

    uart_tx_arbiter #(.NUM_REQ(N), .HDR_EN(0), .HDR_BASE(8'hA0), .TIMEOUT(0)) u_dut_nohdr (
        .i_Clk(clk), .i_Rst(rst), .i_req_valid(valid2), .i_req_byte(byte2),
        .i_req_last(last2), .o_req_ready(ready2), .o_tx_dv(tx_dv2), .o_tx_byte(tx_byte2),
        .i_tx_active(active2), .i_tx_done(done2), .o_grant(grant2), .o_busy(busy2),
        .o_abort(abort2));

    exp_t       exp1[$], exp2[$];
    exp_t       e_mon;
    logic [8:0] sq1[N][$], sq2[N][$];
    logic [8:0] ent;
    int total = 0, bad = 0;
    int rc1[N];
    int ucnt1 = 0, ucnt2 = 0;
    int done_cyc1 = 0, done_cyc2 = -100;
    int dv_cnt2 = 0, abort_cnt1 = 0, abort_cnt2 = 0;
    logic prev_dv1 = 1'b0, prev_dv2 = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic src1(input int k, input logic [7:0] b, input logic l);
        sq1[k].push_back({l, b});
    endtask

    task automatic src2(input int k, input logic [7:0] b, input logic l);
        sq2[k].push_back({l, b});
    endtask

    task automatic push1(input logic [7:0] b, input int k);
        exp1.push_back(exp_t'{b: b, g: N'(1 << k)});
    endtask

    task automatic push2(input logic [7:0] b, input int k);
        exp2.push_back(exp_t'{b: b, g: N'(1 << k)});
    endtask

    // Sources: present queue heads, then retire whatever the DUT accepts.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (sq1[k].size() > 0) begin
                ent = sq1[k][0];
                valid1[k] = 1'b1; byte1[8*k +: 8] = ent[7:0]; last1[k] = ent[8];
            end else begin
                valid1[k] = 1'b0; byte1[8*k +: 8] = 8'h00; last1[k] = 1'b0;
            end
            if (sq2[k].size() > 0) begin
                ent = sq2[k][0];
                valid2[k] = 1'b1; byte2[8*k +: 8] = ent[7:0]; last2[k] = ent[8];
            end else begin
                valid2[k] = 1'b0; byte2[8*k +: 8] = 8'h00; last2[k] = 1'b0;
            end
        end
        #1;
        check_val("ready1_onehot", 32'($countones(ready1) > 1), 0);
        for (int k = 0; k < N; k++) begin
            if (ready1[k]) begin
                rc1[k]++;
                if (valid1[k]) void'(sq1[k].pop_front());
            end
            if (ready2[k] && valid2[k]) void'(sq2[k].pop_front());
        end
    end

    // uart_tx stand-ins plus scoreboard compare on every start pulse.
    always @(negedge clk) begin
        if (rst) begin
            active1 = 1'b0; done1 = 1'b0; ucnt1 = 0;
            active2 = 1'b0; done2 = 1'b0; ucnt2 = 0;
        end else begin
            done1 = 1'b0;
            if (tx_dv1) begin
                check_val("dv1_one_cycle", prev_dv1, 0);
                if (exp1.size() == 0) check_val("dv1_unexpected", exp1.size(), 1);
                else begin
                    e_mon = exp1.pop_front();
                    check_val("tx_byte1", tx_byte1, e_mon.b);
                    check_val("grant1", grant1, e_mon.g);
                end
                active1 = 1'b1; ucnt1 = UART_CYC;
            end else if (active1) begin
                ucnt1--;
                if (ucnt1 == 0) begin active1 = 1'b0; done1 = 1'b1; done_cyc1 = cyc; end
            end
            if (abort1) begin
                abort_cnt1++;
                check_val("abort_latency", cyc - done_cyc1, TO + 1);
                check_val("abort_grant", grant1, 0);
            end

            done2 = 1'b0;
            if (tx_dv2) begin
                dv_cnt2++;
                check_val("dv2_one_cycle", prev_dv2, 0);
                check_val("dv2_gap_ge2", 32'((cyc - done_cyc2) >= 2), 1);
                if (exp2.size() == 0) check_val("dv2_unexpected", exp2.size(), 1);
                else begin
                    e_mon = exp2.pop_front();
                    check_val("tx_byte2", tx_byte2, e_mon.b);
                    check_val("grant2", grant2, e_mon.g);
                end
                active2 = 1'b1; ucnt2 = UART_CYC;
            end else if (active2) begin
                ucnt2--;
                if (ucnt2 == 0) begin active2 = 1'b0; done2 = 1'b1; done_cyc2 = cyc; end
            end
            if (abort2) abort_cnt2++;
        end
        prev_dv1 = tx_dv1;
        prev_dv2 = tx_dv2;
    end

    task automatic drain1(input string tag, input int budget);
        int n = 0;
        while ((exp1.size() != 0 || busy1 || active1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_drain"}, 32'(n < budget), 1);
        check_val({tag, "_busy_end"}, busy1, 0);
        check_val({tag, "_grant_end"}, grant1, 0);
    endtask

    task automatic drain2(input string tag, input int budget);
        int n = 0;
        while ((exp2.size() != 0 || busy2 || active2) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_drain"}, 32'(n < budget), 1);
        check_val({tag, "_busy_end"}, busy2, 0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) rc1[k] = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_val("rst_tx_dv", tx_dv1, 0);
        check_val("rst_tx_byte", tx_byte1, 0);
        check_val("rst_grant", grant1, 0);
        check_val("rst_busy", busy1, 0);
        check_val("rst_abort", abort1, 0);
        check_val("rst_ready", ready1, 0);
        check_val("rst_busy2", busy2, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Contention: all four at once, 1-byte frames, rotate 0..3.
        for (int k = 0; k < N; k++) begin
            rc1[k] = 0;
            push1(8'hA0 | 8'(k), k);
            push1(8'hB0 + 8'(k), k);
            src1(k, 8'hB0 + 8'(k), 1'b1);
        end
        drain1("contention", 3000);
        for (int k = 0; k < N; k++) check_val($sformatf("ready_once%0d", k), rc1[k], 1);

        // Fairness: 0 re-requests straight after its frame while 1 and 3 wait.
        src1(0, 8'hC0, 1'b0); src1(0, 8'hC1, 1'b1); src1(0, 8'hC2, 1'b1);
        src1(1, 8'hD1, 1'b1); src1(3, 8'hD3, 1'b1);
        push1(8'hA0, 0); push1(8'hC0, 0); push1(8'hC1, 0);
        push1(8'hA1, 1); push1(8'hD1, 1);
        push1(8'hA3, 3); push1(8'hD3, 3);
        push1(8'hA0, 0); push1(8'hC2, 0);
        drain1("fairness", 3000);

        // Single frame from source 2.
        src1(2, 8'h11, 1'b0); src1(2, 8'h22, 1'b1);
        push1(8'hA2, 2); push1(8'h11, 2); push1(8'h22, 2);
        drain1("single", 2000);

        // Stall: source 1 stops after one byte; source 2 pending behind it.
        abort_cnt1 = 0;
        src1(1, 8'h51, 1'b0);
        src1(2, 8'h62, 1'b1);
        push1(8'hA1, 1); push1(8'h51, 1);
        push1(8'hA2, 2); push1(8'h62, 2);
        drain1("stall", 3000);
        check_val("abort_count", abort_cnt1, 1);

        // Reset while the header of source 1 is on the wire.
        src1(1, 8'h71, 1'b1);
        push1(8'hA1, 1);
        begin
            int n = 0;
            while (exp1.size() != 0 && n < 500) begin @(negedge clk); n++; end
            check_val("hdr_seen", 32'(n < 500), 1);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_val("midrst_tx_dv", tx_dv1, 0);
        check_val("midrst_tx_byte", tx_byte1, 0);
        check_val("midrst_grant", grant1, 0);
        check_val("midrst_busy", busy1, 0);
        check_val("midrst_abort", abort1, 0);
        for (int k = 0; k < N; k++) sq1[k].delete();
        exp1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        src1(3, 8'h83, 1'b1); src1(0, 8'h80, 1'b1);
        push1(8'hA0, 0); push1(8'h80, 0);
        push1(8'hA3, 3); push1(8'h83, 3);
        drain1("post_reset", 3000);

        // Headerless instance, timeout disabled: long stall mid-frame is tolerated.
        dv_cnt2 = 0; abort_cnt2 = 0;
        src2(3, 8'h31, 1'b0);
        push2(8'h31, 3); push2(8'h32, 3); push2(8'h33, 3);
        repeat (200) @(negedge clk);
        src2(3, 8'h32, 1'b0); src2(3, 8'h33, 1'b1);
        drain2("nohdr", 2000);
        check_val("nohdr_dv_count", dv_cnt2, 3);
        check_val("nohdr_abort_count", abort_cnt2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule
